bcd_seq_converter: RTL

//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one iteration per clock.

---
 rtl/bcd_seq_converter_if.sv | 27 ++
 rtl/bcd_seq_converter.sv | 111 +++++++++++
 2 files changed

// File: rtl/bcd_seq_converter_if.sv
// Start/done request bus for the sequential binary-to-BCD converter.
// Handshake: a request is accepted on any rising edge where start=1 and busy=0.
// bin_in is captured on that edge only. done pulses high for exactly one cycle
// when bcd_out/ovf take a new result. start while busy=1 is dropped, not queued.
interface bcd_seq_converter_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;

    // Requester side
    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, ovf
    );

    // Converter side
    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, ovf
    );
endinterface

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// A conversion takes BIN_W cycles after the accepting edge; results are only
// published on the final iteration so bcd_out never shows scratch contents.
// Digits that do not fit in DIGITS nibbles are dropped and flagged on ovf.
module bcd_seq_converter #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_seq_converter_if.slave bus,
    output logic               o_dbg_state   // 0 = IDLE, 1 = RUN
);

    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BIN_W-1:0] r_shreg;
    logic [SW-1:0]    r_scratch;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_sticky;
    logic [SW-1:0]    r_bcd;
    logic             r_ovf;
    logic             r_done;

    logic [SW-1:0]    w_adj;
    logic [SW-1:0]    w_shifted;
    logic             w_top_out;
    logic             w_last;
    logic             w_accept;

    // Add 3 to every scratch digit of 5..9 so the following shift carries correctly
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted = {w_adj[SW-2:0], r_shreg[BIN_W-1]};
    assign w_top_out = w_adj[SW-1];
    assign w_last    = (r_state == S_RUN) && (r_cnt == CNT_W'(1));
    assign w_accept  = (r_state == S_IDLE) && bus.start;

    // Next-state: a single pass IDLE -> RUN -> IDLE per request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = S_RUN;
            S_RUN:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Iteration datapath: capture on accept, adjust-and-shift while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg      <= '0;
            r_scratch    <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (w_accept) begin
            r_shreg      <= bus.bin_in;
            r_scratch    <= '0;
            r_cnt        <= CNT_W'(BIN_W);
            r_ovf_sticky <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_shreg      <= r_shreg << 1;
            r_scratch    <= w_shifted;
            r_cnt        <= r_cnt - CNT_W'(1);
            r_ovf_sticky <= r_ovf_sticky | w_top_out;
        end
    end

    // Result registers: updated only on the final iteration, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_bcd <= w_shifted;
                r_ovf <= r_ovf_sticky | w_top_out;
            end
        end
    end

    assign bus.busy    = (r_state == S_RUN);
    assign bus.done    = r_done;
    assign bus.bcd_out = r_bcd;
    assign bus.ovf     = r_ovf;
    assign o_dbg_state = r_state;

endmodule
